// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the MEM->WB stage (write-back source ids, entry width, skid FSM states).
package cpu_pkg;
   typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3} wb_src_e;
   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} skid_state_e;
   localparam int WB_ENTRY_W = 32 + 5 + 1;
   function automatic int wb_entry_w(input int dw, input int rw);
      return dw + rw + 1;
   endfunction
endpackage

// File: rtl/wb_src_mux.sv
// wb_src_mux: NSRC:1 write-back source mux; indices past the last source clamp to source NSRC-1.
module wb_src_mux #(
   parameter int DATA_W = 32,
   parameter int NSRC   = 4,
   parameter int SEL_W  = 2
) (
   input  logic [NSRC*DATA_W-1:0] src_i,
   input  logic [SEL_W-1:0]       sel_i,
   output logic [DATA_W-1:0]      data_o
);
   always_comb begin
      data_o = src_i[(NSRC-1)*DATA_W +: DATA_W];
      for (int k = 0; k < NSRC - 1; k++)
         if (int'(sel_i) == k) data_o = src_i[k*DATA_W +: DATA_W];
   end
endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: MEM->WB register stage with valid/ready handshake and 2-entry skid buffer.
// Optional MEM_WB_STATS_EN adds saturating stall_cnt / bubble_cnt outputs.
module mem_wb_pipe_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NSRC   = 4,
   parameter int SEL_W  = 2,
   parameter int REG_W  = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NSRC*DATA_W-1:0] in_src,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic [REG_W-1:0]       in_rd,
   input  logic                   in_regwrite,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [REG_W-1:0]       out_rd,
   output logic                   out_regwrite
`ifdef MEM_WB_STATS_EN
   ,
   output logic [31:0]            stall_cnt,
   output logic [31:0]            bubble_cnt
`endif
);
   localparam int EW = wb_entry_w(DATA_W, REG_W);

   logic [DATA_W-1:0] sel_data;
   logic [EW-1:0]     in_entry, main_q, main_d, skid_q, skid_d;
   skid_state_e       state_q, state_d;
   logic              in_ready_q, in_fire, out_fire;

   wb_src_mux #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W)) u_mux (
      .src_i (in_src),
      .sel_i (in_sel),
      .data_o(sel_data)
   );

   assign in_entry  = {sel_data, in_rd, in_regwrite};
   assign in_ready  = in_ready_q;
   assign in_fire   = in_valid & in_ready_q;
   assign out_valid = state_q != S_EMPTY;
   assign out_fire  = out_valid & out_ready;

   // Data registers are left untouched on flush so a dropped entry never reaches out_data.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) state_d = S_EMPTY;
      else
         case (state_q)
            S_EMPTY: if (in_fire) begin
               state_d = S_ONE;
               main_d  = in_entry;
            end
            S_ONE: if (in_fire & ~out_fire) begin
               state_d = S_TWO;
               skid_d  = in_entry;
            end else if (in_fire) main_d = in_entry;
            else if (out_fire) state_d = S_EMPTY;
            S_TWO: if (out_fire) begin
               state_d = S_ONE;
               main_d  = skid_q;
            end
            default: state_d = S_EMPTY;
         endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= state_d != S_TWO;
      end
   end

   assign {out_data, out_rd} = main_q[EW-1:1];
   assign out_regwrite       = main_q[0] & out_valid;

`ifdef MEM_WB_STATS_EN
   logic [31:0] stall_q, bubble_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (out_valid & ~out_ready & ~&stall_q) stall_q <= stall_q + 32'd1;
         if (~out_valid & ~&bubble_q) bubble_q <= bubble_q + 32'd1;
      end
   end
   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb_mem_wb_pipe_stage: directed + random checks of mem_wb_pipe_stage against a queue-based FIFO model.
module tb_mem_wb_pipe_stage;
   localparam int DW = 32, NS = 3, SW = 2, RW = 5;

   logic           clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0, in_regwrite = 0;
   logic [NS*DW-1:0] in_src = '0;
   logic [SW-1:0]  in_sel = '0;
   logic [RW-1:0]  in_rd = '0;
   logic           in_ready, out_valid, out_regwrite;
   logic [DW-1:0]  out_data;
   logic [RW-1:0]  out_rd;
`ifdef MEM_WB_STATS_EN
   logic [31:0]    stall_cnt, bubble_cnt;
`endif

   mem_wb_pipe_stage #(.DATA_W(DW), .NSRC(NS), .SEL_W(SW), .REG_W(RW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_src(in_src), .in_sel(in_sel), .in_rd(in_rd), .in_regwrite(in_regwrite),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
      .out_regwrite(out_regwrite)
`ifdef MEM_WB_STATS_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [DW-1:0] d; logic [RW-1:0] rd; logic rw;} ent_t;
   ent_t        mq[$];
   logic [DW-1:0] obs[$];
   bit          m_ready = 1;
   longint      m_stall = 0, m_bubble = 0;
   int          ncmp = 0, nfail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_data();
      int idx = (int'(in_sel) >= NS) ? NS - 1 : int'(in_sel);
      return in_src[idx*DW +: DW];
   endfunction

   task automatic tick();
      bit   inf, outf;
      ent_t e;
      inf  = in_valid && m_ready;
      outf = mq.size() > 0 && out_ready;
      e    = '{ref_data(), in_rd, in_regwrite};
      if (outf) obs.push_back(out_data);
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_stall  = 0;
         m_bubble = 0;
      end else begin
         if (mq.size() > 0 && !out_ready) m_stall++;
         if (mq.size() == 0) m_bubble++;
         if (flush) mq.delete();
         else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(e);
         end
      end
      m_ready = mq.size() < 2;
      #1;
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, m_ready);
      chk("out_regwrite", out_regwrite, mq.size() > 0 ? mq[0].rw : 1'b0);
      if (mq.size() > 0) begin
         chk("out_data", out_data, mq[0].d);
         chk("out_rd", out_rd, mq[0].rd);
      end
`ifdef MEM_WB_STATS_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
   endtask

   initial begin
      logic [DW-1:0] exp_d;
      int  nxt, cyc;
      bit  acc, saw_block;
      // reset held two cycles
      tick();
      tick();
      chk("rst_data", out_data, 0);
      chk("rst_rd", out_rd, 0);
      reset = 0;
      tick();
      chk("rel_data", out_data, 0);
      chk("rel_valid", out_valid, 0);
      // single transfer from source 1
      in_src = {$urandom, 32'hDEADBEEF, $urandom};
      in_sel = 1; in_rd = 7; in_regwrite = 1; in_valid = 1; out_ready = 1;
      tick();
      in_valid = 0;
      chk("t2_data", out_data, 32'hDEADBEEF);
      chk("t2_rd", out_rd, 7);
      chk("t2_rw", out_regwrite, 1);
      tick();
      // stream 1..8 with a 3-cycle output stall
      obs.delete();
      nxt = 1; cyc = 0; saw_block = 0; in_sel = 0;
      while (obs.size() < 8 && cyc < 100) begin
         in_valid  = nxt <= 8;
         in_src    = {64'd0, 32'(nxt)};
         in_rd     = 5'(nxt);
         out_ready = !(cyc >= 3 && cyc < 6);
         acc = in_valid && m_ready;
         tick();
         if (!in_ready) saw_block = 1;
         if (acc) nxt++;
         cyc++;
      end
      in_valid = 0;
      chk("t3_count", obs.size(), 8);
      chk("t3_blocked", saw_block, 1);
      for (int i = 0; i < obs.size(); i++) chk("t3_order", obs[i], i + 1);
      // out-of-range select clamps to the last source
      in_src = {$urandom, $urandom, $urandom};
      in_sel = 3; in_valid = 1; exp_d = in_src[2*DW +: DW];
      tick();
      chk("t4_clamp", out_data, exp_d);
      in_sel = 0; exp_d = in_src[DW-1:0];
      tick();
      chk("t4_sel0", out_data, exp_d);
      in_valid = 0;
      tick();
      // fill to TWO, then flush with an incoming entry
      out_ready = 0; in_valid = 1;
      in_src = {64'd0, 32'hA1}; tick();
      in_src = {64'd0, 32'hA2}; tick();
      chk("t5_full", in_ready, 0);
      in_src = {64'd0, 32'hBAD}; flush = 1;
      tick();
      flush = 0;
      chk("t5_valid", out_valid, 0);
      chk("t5_ready", in_ready, 1);
      chk("t5_nobad", out_data !== 32'hBAD, 1);
      in_valid = 0; out_ready = 1;
      tick();
      tick();
`ifdef MEM_WB_STATS_EN
      reset = 1; tick(); reset = 0;
      in_valid = 1; out_ready = 0; tick(); in_valid = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("t6_stall", stall_cnt, 5);
      reset = 1; tick(); reset = 0;
      chk("t6_clear", stall_cnt, 0);
`endif
      // random traffic; a refused entry is held by the source
      for (int i = 0; i < 600; i++) begin
         if (!(in_valid && !m_ready)) begin
            in_valid    = $urandom_range(0, 1);
            in_src      = {$urandom, $urandom, $urandom};
            in_sel      = SW'($urandom);
            in_rd       = RW'($urandom);
            in_regwrite = $urandom_range(0, 1);
         end
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 19) == 0;
         reset     = $urandom_range(0, 99) == 0;
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
